// File: rtl/imem_loadable.sv
// Loadable instruction memory: combinational fetch port plus a valid/ready program
// load port that ends each load with an XOR checksum word and sticky pass/fail flags.
module imem_loadable #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned OP_W   = 3,
    parameter int unsigned DEPTH  = 32,
    localparam int unsigned AW    = WORD_W - OP_W
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [AW-1:0]     Iaddress,
    output logic [WORD_W-1:0] Idata,
    input  logic              load_start,
    input  logic [AW:0]       load_len,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck} state_t;

    state_t            state;
    logic [AW-1:0]     counter;
    logic [AW:0]       length;
    logic [WORD_W-1:0] csum;
    logic [WORD_W-1:0] mem [DEPTH];
    logic              busy;
    logic              xfer;
    logic              len_ok;
    logic              last_word;
    logic              wr_en;

    assign xfer      = ld_valid & busy;
    assign len_ok    = (32'(load_len) >= 32'd1) && (32'(load_len) <= DEPTH);
    assign last_word = (32'(counter) + 32'd1) == 32'(length);
    assign wr_en     = (state == StLoad) && xfer;

    // busy is set/cleared together with the state so both handshake outputs are registered
    assign ld_ready = busy;
    assign cpu_hold = busy;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state     <= StIdle;
            counter   <= '0;
            length    <= '0;
            csum      <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (load_start) begin
                        if (len_ok) begin
                            state     <= StLoad;
                            counter   <= '0;
                            length    <= load_len;
                            csum      <= '0;
                            busy      <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end else begin
                            load_done <= 1'b0;
                            load_err  <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (xfer) begin
                        csum <= csum ^ ld_data;
                        // counter parks on the last index so it never passes DEPTH-1
                        if (last_word) begin
                            state <= StCheck;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (xfer) begin
                        state     <= StIdle;
                        busy      <= 1'b0;
                        load_done <= (ld_data == csum);
                        load_err  <= (ld_data != csum);
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[counter] <= ld_data;
        end
    end

    always_comb begin
        Idata = '0;
        if (32'(Iaddress) < DEPTH) begin
            Idata = mem[Iaddress];
        end
    end

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: queue-based load model checked every cycle, plus
// directed loads with literal expectations.
module tb_imem_loadable;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned AW     = WORD_W - OP_W;

    logic              clock = 1'b0;
    logic              n_reset = 1'b0;
    logic [AW-1:0]     Iaddress = '0;
    logic [WORD_W-1:0] Idata;
    logic              load_start = 1'b0;
    logic [AW:0]       load_len = '0;
    logic [WORD_W-1:0] ld_data = '0;
    logic              ld_valid = 1'b0;
    logic              ld_ready;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int checks = 0;
    int errors = 0;

    imem_loadable #(.WORD_W(WORD_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .Iaddress   (Iaddress),
        .Idata      (Idata),
        .load_start (load_start),
        .load_len   (load_len),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clock = ~clock;

    // Model: words received in the current load are queued; the checksum word is
    // the one arriving after m_len program words.
    logic [WORD_W-1:0] m_mem [DEPTH];
    logic [WORD_W-1:0] got [$];
    bit                m_busy;
    int                m_len;
    bit                m_done;
    bit                m_err;
    int                m_xfers;

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        got.delete();
        m_busy = 0;
        m_len  = 0;
        m_done = 0;
        m_err  = 0;
    endtask

    always @(posedge clock) begin
        if (n_reset) begin
            if (!m_busy) begin
                if (load_start) begin
                    if (int'(load_len) >= 1 && int'(load_len) <= int'(DEPTH)) begin
                        m_busy = 1;
                        m_len  = int'(load_len);
                        got.delete();
                    end
                    m_done = 0;
                    m_err  = !m_busy;
                end
            end else if (ld_valid) begin
                logic [WORD_W-1:0] x;
                got.push_back(ld_data);
                m_xfers++;
                if (got.size() <= m_len) begin
                    m_mem[got.size() - 1] = ld_data;
                end else begin
                    x = '0;
                    for (int i = 0; i < m_len; i++) x ^= got[i];
                    m_done = (x == got[m_len]);
                    m_err  = !m_done;
                    m_busy = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        check("cpu_hold", 32'(cpu_hold), 32'(m_busy));
        check("ld_ready", 32'(ld_ready), 32'(m_busy));
        check("load_done", 32'(load_done), 32'(m_done));
        check("load_err", 32'(load_err), 32'(m_err));
        if (!cpu_hold) check("idata", 32'(Idata), 32'(m_mem[Iaddress]));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start(input int len);
        load_start = 1'b1;
        load_len   = (AW + 1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [WORD_W-1:0] w, input bit bubble);
        int n = 0;
        while (!ld_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            errors++;
            checks++;
            $display("FAIL ld_ready_timeout at %0t: got 0 expected 1", $time);
        end
        ld_valid = 1'b1;
        ld_data  = w;
        tick();
        ld_valid = 1'b0;
        if (bubble) tick();
    endtask

    task automatic sweep();
        for (int a = 0; a < int'(DEPTH); a++) begin
            Iaddress = AW'(a);
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog at %0t: got timeout expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int x0;
        model_reset();
        m_xfers = 0;
        #12 n_reset = 1'b1;
        tick();

        // reset state
        check("rst_idata0", 32'(Idata), 32'h0);
        check("rst_hold", 32'(cpu_hold), 32'h0);
        check("rst_ready", 32'(ld_ready), 32'h0);
        sweep();

        // good 3-word load
        start(3);
        check("hold_after_start", 32'(cpu_hold), 32'h1);
        send(8'h1E, 0);
        send(8'h21, 0);
        send(8'h4B, 0);
        check("hold_before_csum", 32'(cpu_hold), 32'h1);
        send(8'h74, 0);
        check("hold_after_csum", 32'(cpu_hold), 32'h0);
        check("done_good", 32'(load_done), 32'h1);
        check("err_good", 32'(load_err), 32'h0);
        Iaddress = 5'd0; #1 check("addr0", 32'(Idata), 32'h1E);
        Iaddress = 5'd1; #1 check("addr1", 32'(Idata), 32'h21);
        Iaddress = 5'd2; #1 check("addr2", 32'(Idata), 32'h4B);
        Iaddress = 5'd3; #1 check("addr3", 32'(Idata), 32'h00);
        tick();

        // same load, bad checksum
        start(3);
        send(8'h1E, 0);
        send(8'h21, 0);
        send(8'h4B, 0);
        send(8'h00, 0);
        check("done_bad", 32'(load_done), 32'h0);
        check("err_bad", 32'(load_err), 32'h1);
        check("hold_bad", 32'(cpu_hold), 32'h0);
        Iaddress = 5'd0; #1 check("addr0_bad", 32'(Idata), 32'h1E);
        tick();

        // full depth with bubbles
        x0 = m_xfers;
        start(32);
        for (int i = 0; i < 32; i++) send(8'(i), 1);
        send(8'h00, 1);
        check("xfer_count", 32'(m_xfers - x0), 32'd33);
        check("done_full", 32'(load_done), 32'h1);
        Iaddress = 5'd31; #1 check("addr31", 32'(Idata), 32'h1F);
        Iaddress = 5'd7;  #1 check("addr7", 32'(Idata), 32'h07);
        tick();

        // bad lengths; stray ld_valid in IDLE must not write
        start(0);
        check("err_len0", 32'(load_err), 32'h1);
        check("done_len0", 32'(load_done), 32'h0);
        ld_valid = 1'b1; ld_data = 8'hFF;
        tick(); tick();
        ld_valid = 1'b0;
        start(33);
        check("err_len33", 32'(load_err), 32'h1);
        check("ready_len33", 32'(ld_ready), 32'h0);
        tick();
        sweep();

        // reset mid-load
        start(5);
        send(8'h11, 0);
        send(8'h22, 0);
        n_reset = 1'b0;
        model_reset();
        #2 check("rst_mid_hold", 32'(cpu_hold), 32'h0);
        check("rst_mid_err", 32'(load_err), 32'h0);
        #5 n_reset = 1'b1;
        tick();
        Iaddress = 5'd0; #1 check("rst_mid_addr0", 32'(Idata), 32'h00);
        Iaddress = 5'd31; #1 check("rst_mid_addr31", 32'(Idata), 32'h00);
        sweep();

        // one-word load after reset
        start(1);
        send(8'hA5, 0);
        send(8'hA5, 0);
        check("done_one", 32'(load_done), 32'h1);
        Iaddress = 5'd0; #1 check("one_addr0", 32'(Idata), 32'hA5);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
